vga_fb_pixel_stream: RTL and testbench

VGA_FB_PIXEL_STREAM -- requirements
Module: vga_fb_pixel_stream

---
 rtl/vga_fb_pixel_stream.sv | 262 ++++++++++++++++++++++++++
 tb/tb_vga_fb_pixel_stream.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_fb_pixel_stream.sv
// rtl/vga_fb_pixel_stream.sv - VGA raster generator fetching pixels over AXI-Lite into a backpressured pixel stream
module vga_fb_pixel_stream_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic             empty_o,
    output logic             full_o,
    output logic [CW-1:0]    count_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    assign empty_o    = (count_q == '0);
    assign full_o     = (count_q == CW'(DEPTH));
    assign count_o    = count_q;
    assign do_push    = push_i && !full_o;
    assign do_pop     = pop_i && !empty_o;
    assign pop_data_o = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

module vga_fb_pixel_stream #(
    parameter int AXI_ADDR_WIDTH  = 20,
    parameter int AXI_DATA_WIDTH  = 16,
    parameter int COLOR_BITS      = 4,
    parameter int MAX_OUTSTANDING = 4,
    parameter int CTX_DEPTH       = 16,
    parameter int H_VISIBLE       = 640,
    parameter int H_FRONT_PORCH   = 16,
    parameter int H_SYNC_PULSE    = 96,
    parameter int H_BACK_PORCH    = 48,
    parameter int H_WHOLE_LINE    = 800,
    parameter int V_VISIBLE       = 480,
    parameter int V_FRONT_PORCH   = 10,
    parameter int V_SYNC_PULSE    = 2,
    parameter int V_BACK_PORCH    = 33,
    parameter int V_WHOLE_FRAME   = 525
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [AXI_ADDR_WIDTH-1:0] fb_base,
    output logic [AXI_ADDR_WIDTH-1:0] axi_araddr,
    output logic                      axi_arvalid,
    input  logic                      axi_arready,
    input  logic [AXI_DATA_WIDTH-1:0] axi_rdata,
    input  logic [1:0]                axi_rresp,
    input  logic                      axi_rvalid,
    output logic                      axi_rready,
    output logic                      hsync,
    output logic                      vsync,
    output logic [COLOR_BITS-1:0]     red,
    output logic [COLOR_BITS-1:0]     green,
    output logic [COLOR_BITS-1:0]     blue,
    output logic                      valid,
    input  logic                      ready,
    output logic                      frame_start,
    output logic                      rd_error
);
    localparam int HW   = $clog2(H_WHOLE_LINE);
    localparam int VW   = $clog2(V_WHOLE_FRAME);
    localparam int NPIX = H_VISIBLE * V_VISIBLE;
    localparam int PW   = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int OW   = $clog2(MAX_OUTSTANDING + 1);
    localparam int CRW  = OW + 2;
    localparam int CCW  = $clog2(CTX_DEPTH + 1);
    localparam int RGBW = 3 * COLOR_BITS;
    localparam int HS0  = H_VISIBLE + H_FRONT_PORCH;
    localparam int VS0  = V_VISIBLE + V_FRONT_PORCH;

    logic                      en_q, started_q, started_d;
    logic [HW-1:0]             h_q, h_d;
    logic [VW-1:0]             v_q, v_d;
    logic [PW-1:0]             pix_q, pix_d;
    logic [AXI_ADDR_WIDTH-1:0] base_q, base_d, araddr_q, araddr_d;
    logic                      arvalid_q, arvalid_d, fs_q, fs_d;
    logic [OW-1:0]             out_q, out_d;
    logic                      rd_error_q, rd_error_d;
    logic                      valid_q, valid_d, hsync_q, hsync_d, vsync_q, vsync_d;
    logic [COLOR_BITS-1:0]     red_q, red_d, green_q, green_d, blue_q, blue_d;

    logic slot_vis, slot_hs, slot_vs, ar_accept, r_hs, credit_ok, advance, load;
    logic ctx_full, ctx_empty, d_empty;
    logic [2:0]      ctx_data;
    logic [RGBW-1:0] d_data;
    logic [OW-1:0]   d_count;
    logic [CCW-1:0]  unused_ctx_count;
    logic            unused_d_full, unused_rdata;

    assign unused_rdata = ^axi_rdata;
    assign axi_rready   = !reset;
    assign ar_accept    = arvalid_q && axi_arready;
    // Responses with nothing outstanding belong to reads issued before a reset.
    assign r_hs         = axi_rvalid && (out_q != '0);

    assign slot_vis = (int'(h_q) < H_VISIBLE) && (int'(v_q) < V_VISIBLE);
    assign slot_hs  = !((int'(h_q) >= HS0) && (int'(h_q) < HS0 + H_SYNC_PULSE));
    assign slot_vs  = !((int'(v_q) >= VS0) && (int'(v_q) < VS0 + V_SYNC_PULSE));

    // Credits cover pending, in-flight and buffered reads so the data FIFO can never overflow.
    assign credit_ok = (CRW'(out_q) + CRW'(arvalid_q) + CRW'(d_count)) < CRW'(MAX_OUTSTANDING);
    assign advance   = en_q && started_q && !ctx_full &&
                       (!slot_vis || ((!arvalid_q || axi_arready) && credit_ok));

    always_comb begin
        h_d        = h_q;
        v_d        = v_q;
        pix_d      = pix_q;
        base_d     = base_q;
        started_d  = started_q;
        fs_d       = 1'b0;
        arvalid_d  = arvalid_q && !axi_arready;
        araddr_d   = araddr_q;
        out_d      = out_q;
        rd_error_d = rd_error_q || (r_hs && (axi_rresp != 2'b00));
        if (en_q && !started_q) begin
            started_d = 1'b1;
            base_d    = fb_base;
            fs_d      = 1'b1;
        end
        if (advance) begin
            if (slot_vis) begin
                arvalid_d = 1'b1;
                araddr_d  = base_q + AXI_ADDR_WIDTH'(pix_q);
                if (pix_q == PW'(NPIX - 1)) begin
                    pix_d  = '0;
                    base_d = fb_base;
                    fs_d   = 1'b1;
                end else begin
                    pix_d = pix_q + 1'b1;
                end
            end
            if (h_q == HW'(H_WHOLE_LINE - 1)) begin
                h_d = '0;
                v_d = (v_q == VW'(V_WHOLE_FRAME - 1)) ? '0 : v_q + 1'b1;
            end else begin
                h_d = h_q + 1'b1;
            end
        end
        case ({ar_accept, r_hs})
            2'b10:   out_d = out_q + 1'b1;
            2'b01:   out_d = out_q - 1'b1;
            default: out_d = out_q;
        endcase
    end

    assign load = (!valid_q || ready) && !ctx_empty && (!ctx_data[2] || !d_empty);

    always_comb begin
        valid_d = valid_q;
        hsync_d = hsync_q;
        vsync_d = vsync_q;
        red_d   = red_q;
        green_d = green_q;
        blue_d  = blue_q;
        if (load) begin
            valid_d = 1'b1;
            hsync_d = ctx_data[1];
            vsync_d = ctx_data[0];
            red_d   = ctx_data[2] ? d_data[RGBW-1 -: COLOR_BITS] : '0;
            green_d = ctx_data[2] ? d_data[2*COLOR_BITS-1 -: COLOR_BITS] : '0;
            blue_d  = ctx_data[2] ? d_data[COLOR_BITS-1:0] : '0;
        end else if (ready) begin
            valid_d = 1'b0;
        end
    end

    vga_fb_pixel_stream_fifo #(.WIDTH(3), .DEPTH(CTX_DEPTH), .CW(CCW)) u_ctx_fifo (
        .clk(clk), .reset(reset),
        .push_i(advance), .push_data_i({slot_vis, slot_hs, slot_vs}),
        .pop_i(load), .pop_data_o(ctx_data),
        .empty_o(ctx_empty), .full_o(ctx_full), .count_o(unused_ctx_count)
    );

    vga_fb_pixel_stream_fifo #(.WIDTH(RGBW), .DEPTH(MAX_OUTSTANDING), .CW(OW)) u_data_fifo (
        .clk(clk), .reset(reset),
        .push_i(r_hs), .push_data_i(axi_rdata[AXI_DATA_WIDTH-1 -: RGBW]),
        .pop_i(load && ctx_data[2]), .pop_data_o(d_data),
        .empty_o(d_empty), .full_o(unused_d_full), .count_o(d_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            en_q       <= 1'b0;
            started_q  <= 1'b0;
            h_q        <= '0;
            v_q        <= '0;
            pix_q      <= '0;
            base_q     <= '0;
            arvalid_q  <= 1'b0;
            araddr_q   <= '0;
            fs_q       <= 1'b0;
            out_q      <= '0;
            rd_error_q <= 1'b0;
            valid_q    <= 1'b0;
            hsync_q    <= 1'b1;
            vsync_q    <= 1'b1;
            red_q      <= '0;
            green_q    <= '0;
            blue_q     <= '0;
        end else begin
            en_q       <= enable;
            started_q  <= started_d;
            h_q        <= h_d;
            v_q        <= v_d;
            pix_q      <= pix_d;
            base_q     <= base_d;
            arvalid_q  <= arvalid_d;
            araddr_q   <= araddr_d;
            fs_q       <= fs_d;
            out_q      <= out_d;
            rd_error_q <= rd_error_d;
            valid_q    <= valid_d;
            hsync_q    <= hsync_d;
            vsync_q    <= vsync_d;
            red_q      <= red_d;
            green_q    <= green_d;
            blue_q     <= blue_d;
        end
    end

    assign axi_arvalid = arvalid_q;
    assign axi_araddr  = araddr_q;
    assign frame_start = fs_q;
    assign rd_error    = rd_error_q;
    assign valid       = valid_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign red         = red_q;
    assign green       = green_q;
    assign blue        = blue_q;
endmodule

// File: tb/tb_vga_fb_pixel_stream.sv
// tb/tb_vga_fb_pixel_stream.sv - randomized self-checking bench for vga_fb_pixel_stream against a raster-order reference model
module tb_vga_fb_pixel_stream;
    localparam int AW = 20, DW = 16, CB = 4, MO = 2, CD = 16;
    localparam int HV = 4, HFP = 0, HSP = 1, HBP = 1, HWL = 6;
    localparam int VV = 2, VFP = 0, VSP = 1, VBP = 0, VWF = 3;
    localparam int NPIX = HV * VV, SLOTS = HWL * VWF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, enable, axi_arvalid, axi_arready, axi_rvalid, axi_rready;
    logic hsync, vsync, valid, ready, frame_start, rd_error;
    logic [AW-1:0] fb_base, axi_araddr;
    logic [DW-1:0] axi_rdata;
    logic [1:0]    axi_rresp;
    logic [CB-1:0] red, green, blue;

    vga_fb_pixel_stream #(
        .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .COLOR_BITS(CB),
        .MAX_OUTSTANDING(MO), .CTX_DEPTH(CD),
        .H_VISIBLE(HV), .H_FRONT_PORCH(HFP), .H_SYNC_PULSE(HSP), .H_BACK_PORCH(HBP), .H_WHOLE_LINE(HWL),
        .V_VISIBLE(VV), .V_FRONT_PORCH(VFP), .V_SYNC_PULSE(VSP), .V_BACK_PORCH(VBP), .V_WHOLE_FRAME(VWF)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .fb_base(fb_base),
        .axi_araddr(axi_araddr), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
        .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
        .hsync(hsync), .vsync(vsync), .red(red), .green(green), .blue(blue),
        .valid(valid), .ready(ready), .frame_start(frame_start), .rd_error(rd_error)
    );

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } rsp_t;

    int   n_cmp = 0, n_fail = 0, cyc = 0;
    int   base_tab [512];
    rsp_t rq [$];
    int   lat = 1, stall_cnt = 0, late_cnt = 0;
    bit   rand_ar = 0, rand_rdy = 0, err_next = 0;
    int   n_ar = 0, n_out = 0, n_fs = 0, inflight = 0;
    bit   prev_stall = 0, prev_ar_pend = 0;
    logic [14:0]   prev_out;
    logic [AW-1:0] prev_araddr;

    function automatic logic [13:0] exp_out(int s);
        int f, p, h, v;
        logic hs, vs;
        logic [AW-1:0] a;
        logic [11:0] rgb;
        f = s / SLOTS;
        if (f > 511) f = 511;
        p = s % SLOTS;
        v = p / HWL;
        h = p % HWL;
        hs = !((h >= HV + HFP) && (h < HV + HFP + HSP));
        vs = !((v >= VV + VFP) && (v < VV + VFP + VSP));
        rgb = '0;
        if (h < HV && v < VV) begin
            a = AW'(base_tab[f] + v * HV + h);
            rgb = a[15:4];
        end
        return {hs, vs, rgb};
    endfunction

    task automatic model_reset(int b);
        rq.delete();
        n_ar = 0; n_out = 0; n_fs = 0; inflight = 0;
        prev_stall = 0; prev_ar_pend = 0; err_next = 0;
        for (int i = 0; i < 512; i++) base_tab[i] = b;
    endtask

    task automatic step();
        logic [13:0] exp;
        logic [AW-1:0] ea;
        bit late;
        int f;
        @(negedge clk);
        cyc++;
        late = 0;
        if (reset) begin prev_stall = 0; prev_ar_pend = 0; end
        if (!reset && frame_start) n_fs++;
        if (prev_stall) begin
            n_cmp++;
            if ({valid, hsync, vsync, red, green, blue} !== prev_out) begin
                n_fail++;
                $display("FAIL hold_under_backpressure: got %h want %h", {valid, hsync, vsync, red, green, blue}, prev_out);
            end
        end
        if (prev_ar_pend) begin
            n_cmp++;
            if ({axi_arvalid, axi_araddr} !== {1'b1, prev_araddr}) begin
                n_fail++;
                $display("FAIL ar_stable: got valid=%b addr=%h want valid=1 addr=%h", axi_arvalid, axi_araddr, prev_araddr);
            end
        end
        axi_arready = rand_ar ? 1'($urandom_range(0, 1)) : 1'b1;
        if (stall_cnt > 0) begin ready = 1'b0; stall_cnt--; end
        else ready = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
        axi_rresp = 2'b00;
        axi_rdata = DW'($urandom);
        if (late_cnt > 0) begin
            axi_rvalid = 1'b1; axi_rresp = 2'b10; late = 1; late_cnt--;
        end else if (rq.size() > 0 && rq[0].due <= cyc) begin
            axi_rvalid = 1'b1; axi_rdata = rq[0].data;
            if (err_next) begin axi_rresp = 2'b10; err_next = 0; end
        end else begin
            axi_rvalid = 1'b0;
        end
        if (!reset) begin
            if (axi_arvalid && axi_arready) begin
                f = n_ar / NPIX;
                if (f > 511) f = 511;
                ea = AW'(base_tab[f] + n_ar % NPIX);
                n_cmp++;
                if (axi_araddr !== ea) begin
                    n_fail++;
                    $display("FAIL araddr #%0d: got %h want %h", n_ar, axi_araddr, ea);
                end
                if (n_ar % NPIX == 0) begin
                    n_cmp++;
                    if (n_fs != f + 1) begin
                        n_fail++;
                        $display("FAIL frame_start_count at frame %0d: got %0d want %0d", f, n_fs, f + 1);
                    end
                end
                rq.push_back('{axi_araddr[DW-1:0], cyc + lat});
                n_ar++; inflight++;
            end
            if (axi_rvalid && !late) begin
                n_cmp++;
                if (axi_rready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL rready: got %b want 1", axi_rready);
                end
                void'(rq.pop_front());
                inflight--;
            end
            n_cmp++;
            if (inflight > MO) begin
                n_fail++;
                $display("FAIL outstanding: got %0d want <= %0d", inflight, MO);
            end
            if (valid && ready) begin
                exp = exp_out(n_out);
                n_cmp++;
                if ({hsync, vsync, red, green, blue} !== exp) begin
                    n_fail++;
                    $display("FAIL pixel #%0d: got %h want %h", n_out, {hsync, vsync, red, green, blue}, exp);
                end
                n_out++;
            end
            prev_stall   = valid && !ready;
            prev_out     = {valid, hsync, vsync, red, green, blue};
            prev_ar_pend = axi_arvalid && !axi_arready;
            prev_araddr  = axi_araddr;
        end
    endtask

    task automatic test_reset();
        reset = 1; enable = 0; fb_base = 20'h00100;
        for (int i = 0; i < 3; i++) step();
        n_cmp += 8;
        if (axi_arvalid !== 1'b0) begin n_fail++; $display("FAIL reset_arvalid: got %b want 0", axi_arvalid); end
        if (axi_rready !== 1'b0) begin n_fail++; $display("FAIL reset_rready: got %b want 0", axi_rready); end
        if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid); end
        if (hsync !== 1'b1) begin n_fail++; $display("FAIL reset_hsync: got %b want 1", hsync); end
        if (vsync !== 1'b1) begin n_fail++; $display("FAIL reset_vsync: got %b want 1", vsync); end
        if ({red, green, blue} !== 12'h000) begin n_fail++; $display("FAIL reset_rgb: got %h want 000", {red, green, blue}); end
        if (frame_start !== 1'b0) begin n_fail++; $display("FAIL reset_frame_start: got %b want 0", frame_start); end
        if (rd_error !== 1'b0) begin n_fail++; $display("FAIL reset_rd_error: got %b want 0", rd_error); end
        model_reset(32'h100);
        reset = 0;
        for (int i = 0; i < 4; i++) step();
        n_cmp++;
        if (axi_arvalid !== 1'b0 || n_fs != 0) begin
            n_fail++; $display("FAIL idle_without_enable: arvalid=%b pulses=%0d want 0/0", axi_arvalid, n_fs);
        end
    endtask

    task automatic test_basic();
        int k = 0;
        enable = 1;
        while (n_out < 2 * SLOTS + 2 && k < 1000) begin step(); k++; end
        n_cmp++;
        if (n_out < 2 * SLOTS + 2) begin n_fail++; $display("FAIL basic_timeout: outputs %0d want %0d", n_out, 2 * SLOTS + 2); end
    endtask

    task automatic test_latency();
        int k = 0, tgt;
        lat = 5; rand_ar = 1; tgt = n_out + 2 * SLOTS;
        while (n_out < tgt && k < 3000) begin step(); k++; end
        n_cmp++;
        if (n_out < tgt) begin n_fail++; $display("FAIL latency_timeout: outputs %0d want %0d", n_out, tgt); end
        lat = 1; rand_ar = 0;
    endtask

    task automatic test_backpressure();
        int k = 0, tgt;
        while (!(n_out % SLOTS == 1 && valid) && k < 200) begin step(); k++; end
        stall_cnt = 20;
        for (int i = 0; i < 20; i++) step();
        n_cmp++;
        if (valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid: got %b want 1", valid); end
        rand_rdy = 1; tgt = n_out + 3 * SLOTS; k = 0;
        while (n_out < tgt && k < 2000) begin step(); k++; end
        n_cmp++;
        if (n_out < tgt) begin n_fail++; $display("FAIL backpressure_timeout: outputs %0d want %0d", n_out, tgt); end
        rand_rdy = 0;
    endtask

    task automatic test_base_change();
        int k = 0, f, tgt;
        while (n_ar % NPIX != 2 && k < 200) begin step(); k++; end
        f = n_ar / NPIX;
        fb_base = 20'h00200;
        for (int i = f + 1; i < 512; i++) base_tab[i] = 32'h200;
        tgt = (f + 3) * SLOTS; k = 0;
        while (n_out < tgt && k < 2000) begin step(); k++; end
        n_cmp++;
        if (n_out < tgt) begin n_fail++; $display("FAIL base_change_timeout: outputs %0d want %0d", n_out, tgt); end
    endtask

    task automatic test_enable_drain();
        int k = 0, tgt;
        while (n_ar % NPIX != 5 && k < 200) begin step(); k++; end
        enable = 0;
        for (int i = 0; i < 40; i++) step();
        n_cmp += 2;
        if (valid !== 1'b0 || axi_arvalid !== 1'b0) begin
            n_fail++; $display("FAIL drain_idle: valid=%b arvalid=%b want 0/0", valid, axi_arvalid);
        end
        if (inflight != 0) begin n_fail++; $display("FAIL drain_outstanding: got %0d want 0", inflight); end
        enable = 1; tgt = n_out + 2 * SLOTS; k = 0;
        while (n_out < tgt && k < 1000) begin step(); k++; end
        n_cmp++;
        if (n_out < tgt) begin n_fail++; $display("FAIL resume_timeout: outputs %0d want %0d", n_out, tgt); end
    endtask

    task automatic test_rd_error();
        int k = 0, tgt;
        n_cmp++;
        if (rd_error !== 1'b0) begin n_fail++; $display("FAIL rd_error_clean: got %b want 0", rd_error); end
        err_next = 1;
        while (err_next && k < 200) begin step(); k++; end
        for (int i = 0; i < 3; i++) step();
        n_cmp++;
        if (rd_error !== 1'b1) begin n_fail++; $display("FAIL rd_error_set: got %b want 1", rd_error); end
        tgt = n_out + SLOTS; k = 0;
        while (n_out < tgt && k < 1000) begin step(); k++; end
        n_cmp++;
        if (rd_error !== 1'b1 || n_out < tgt) begin
            n_fail++; $display("FAIL rd_error_sticky: got %b outputs %0d want 1 and %0d", rd_error, n_out, tgt);
        end
    endtask

    task automatic test_reset_midop();
        int k = 0, tgt;
        lat = 5;
        while (inflight != MO && k < 300) begin step(); k++; end
        n_cmp++;
        if (inflight != MO) begin n_fail++; $display("FAIL reach_outstanding: got %0d want %0d", inflight, MO); end
        reset = 1;
        step(); step();
        model_reset(32'h300);
        fb_base = 20'h00300; enable = 0; reset = 0; late_cnt = 6;
        for (int i = 0; i < 10; i++) begin
            step();
            n_cmp++;
            if (valid !== 1'b0 || axi_arvalid !== 1'b0) begin
                n_fail++; $display("FAIL post_reset_quiet cycle %0d: valid=%b arvalid=%b want 0/0", i, valid, axi_arvalid);
            end
        end
        n_cmp++;
        if (rd_error !== 1'b0) begin n_fail++; $display("FAIL late_rresp_ignored: got %b want 0", rd_error); end
        enable = 1; tgt = SLOTS + 4; k = 0;
        while (n_out < tgt && k < 2000) begin step(); k++; end
        n_cmp++;
        if (n_out < tgt) begin n_fail++; $display("FAIL restart_timeout: outputs %0d want %0d", n_out, tgt); end
        lat = 1;
    endtask

    initial begin
        reset = 1; enable = 0; fb_base = 20'h00100; ready = 1;
        axi_arready = 1; axi_rvalid = 0; axi_rdata = '0; axi_rresp = 2'b00;
        model_reset(32'h100);
        test_reset();
        test_basic();
        test_latency();
        test_backpressure();
        test_base_change();
        test_enable_drain();
        test_rd_error();
        test_reset_midop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
